dummy_hls_ip_source_ctrl: RTL

DUMMY_HLS_IP_SOURCE_CTRL -- requirements
Module: dummy_hls_ip_source_ctrl

---
 rtl/dummy_hls_ip_package.sv | 33 +++
 rtl/dummy_hls_ip_rdata_fifo.sv | 76 +++++++
 rtl/dummy_hls_ip_source_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dummy_hls_ip_package.sv
// Shared types and helpers for the HLS IP source controller.
package dummy_hls_ip_package;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned SIZE_WIDTH = 16;

    // Controller FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Start request bundle coming from the controller FSM.
    typedef struct packed {
        logic                  req_start;
        logic [ADDR_WIDTH-1:0] base_addr;
        logic [SIZE_WIDTH-1:0] trans_size;
    } ctrl_t;

    // Status flags returned to the controller FSM.
    typedef struct packed {
        logic ready_start;
        logic done;
    } flags_t;

    // Byte address of word number idx; wraps modulo 2^32 by construction.
    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [SIZE_WIDTH-1:0] idx);
        return base + {{(ADDR_WIDTH-SIZE_WIDTH-2){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/dummy_hls_ip_rdata_fifo.sv
// Response buffer between TCDM read data and the output stream.
// Head word is presented combinationally; reads back as zero while empty.
module dummy_hls_ip_rdata_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      push_i,
    input  logic [DATA_WIDTH-1:0]     data_i,
    input  logic                      pop_i,
    output logic [DATA_WIDTH-1:0]     data_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next pointer/count; clear flushes everything regardless of traffic.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: ;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk_i) begin
        // NOTE: storage has no reset; its contents are never observed while empty, so it maps to plain RAM/flops.
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/dummy_hls_ip_source_ctrl.sv
// Reads trans_size words from TCDM starting at base_addr and streams them out
// in address order, issuing reads only while buffer space is guaranteed.
module dummy_hls_ip_source_ctrl
    import dummy_hls_ip_package::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  req_start_i,
    input  logic [31:0]           base_addr_i,
    input  logic [15:0]           trans_size_i,
    output logic                  ready_start_o,
    output logic                  done_o,
    output logic                  tcdm_req_o,
    input  logic                  tcdm_gnt_i,
    output logic [31:0]           tcdm_add_o,
    output logic                  tcdm_wen_o,
    input  logic [DATA_WIDTH-1:0] tcdm_r_data_i,
    input  logic                  tcdm_r_valid_i,
    output logic [DATA_WIDTH-1:0] stream_data_o,
    output logic                  stream_valid_o,
    input  logic                  stream_ready_i
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [SIZE_WIDTH-1:0] size_q, size_d;
    logic [SIZE_WIDTH-1:0] issued_q, issued_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic                  zero_done_q, zero_done_d;

    logic [CW-1:0]         fifo_count;
    logic                  fifo_full, fifo_empty, fifo_pop;
    logic [CW:0]           in_use;
    logic                  gnt_hs, rsp_acc, drain_done;
    ctrl_t                 ctrl;
    flags_t                flags;

    assign ctrl = '{req_start: req_start_i, base_addr: base_addr_i, trans_size: trans_size_i};

    // Buffer slots already spoken for: words waiting plus reads in flight.
    assign in_use = {1'b0, fifo_count} + {1'b0, outst_q};

    assign tcdm_req_o = (state_q == ST_RUN) && !clear_i && (issued_q < size_q)
                        && !fifo_full && (in_use < (CW+1)'(FIFO_DEPTH));
    assign tcdm_add_o = word_addr(base_q, issued_q);
    assign tcdm_wen_o = 1'b1;
    assign gnt_hs     = tcdm_req_o && tcdm_gnt_i;
    // Responses only count while a transfer owns the bus; stale ones are dropped.
    assign rsp_acc    = tcdm_r_valid_i && (state_q != ST_IDLE) && (outst_q != '0);

    assign stream_valid_o = !fifo_empty;
    assign fifo_pop       = stream_valid_o && stream_ready_i;

    assign ready_start_o = flags.ready_start;
    assign done_o        = flags.done;

    dummy_hls_ip_rdata_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_rdata_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (rsp_acc),
        .data_i  (tcdm_r_data_i),
        .pop_i   (fifo_pop),
        .data_o  (stream_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Next state, counters and status flags.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        size_d      = size_q;
        issued_d    = issued_q;
        outst_d     = outst_q;
        zero_done_d = 1'b0;
        drain_done  = 1'b0;

        if (gnt_hs) issued_d = issued_q + 16'd1;

        unique case ({gnt_hs, rsp_acc})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: ;
        endcase

        unique case (state_q)
            ST_IDLE: begin
                if (ctrl.req_start) begin
                    if (ctrl.trans_size == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        base_d   = ctrl.base_addr;
                        size_d   = ctrl.trans_size;
                        issued_d = '0;
                        outst_d  = '0;
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (gnt_hs && (issued_q + 16'd1 == size_q)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((outst_q == '0) && fifo_empty) begin
                    drain_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear_i) begin
            state_d     = ST_IDLE;
            issued_d    = '0;
            outst_d     = '0;
            zero_done_d = 1'b0;
        end

        flags.ready_start = (state_q == ST_IDLE);
        flags.done        = !clear_i && (zero_done_q || drain_done);
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            size_q      <= '0;
            issued_q    <= '0;
            outst_q     <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            size_q      <= size_d;
            issued_q    <= issued_d;
            outst_q     <= outst_d;
            zero_done_q <= zero_done_d;
        end
    end

endmodule
